seq_divider: RTL

- Multi-cycle restoring unsigned divider; the inverse of the ALU multiply path.
- Recovers quotient and remainder from an 8-bit product-width dividend and a 4-bit operand-width divisor.
- Start/busy/done handshake, so a controller can issue operations back-to-back alongside the registered ALU.
- Computes one quotient bit per clock, MSB first.

---
 rtl/seq_divider_if.sv | 25 ++
 rtl/seq_divider.sv | 134 +++++++++++++
 2 files changed

// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The master issues operations, the slave (the divider) returns results.
interface seq_divider_if #(
    parameter int DW = 8,
    parameter int VW = 4
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring unsigned divider: one quotient bit per clock, MSB first.
// Start is honoured in IDLE or DONE, so operations can run back-to-back.
module seq_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic             clk,
    input  logic             rst,
    seq_divider_if.slave     bus
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] sr_q, sr_d;
    logic [VW:0]   part_q, part_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          dbz_q, dbz_d;

    logic [VW:0]   shifted;
    logic [VW:0]   trial;
    logic          qbit;
    logic [VW:0]   part_iter;
    logic [DW-1:0] sr_iter;

    // One restoring step: the partial remainder is always below the divisor,
    // so after the shift it fits VW+1 bits and the top bit of part_q is spare.
    always_comb begin
        shifted   = (VW+1)'({part_q, sr_q[DW-1]});
        trial     = shifted - {1'b0, dvs_q};
        qbit      = (shifted >= {1'b0, dvs_q});
        part_iter = qbit ? trial : shifted;
        sr_iter   = {sr_q[DW-2:0], qbit};
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        part_d  = part_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    sr_d   = bus.dividend;
                    dvs_d  = bus.divisor;
                    part_d = '0;
                    cnt_d  = '0;
                    if (bus.divisor == '0) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        quot_d  = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_CALC;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_CALC: begin
                sr_d   = sr_iter;
                part_d = part_iter;
                cnt_d  = cnt_q + 1'b1;
                // The final iteration and the result load share one edge.
                if (cnt_q == CW'(DW-1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quot_d  = sr_iter;
                    rem_d   = part_iter[VW-1:0];
                    dbz_d   = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            part_q  <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            part_q  <= part_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule
